// File: rtl/srl16_fifo_ctrl.sv
// ============================================================================
//  Module      : srl16_fifo_ctrl
//  Description : Sequencer that runs a parent-instantiated bank of WIDTH
//                falling-edge SRL16E_1 primitives as a 16-deep first-word-
//                fall-through FIFO. Optional ALMOST_FULL output is enabled by
//                defining SRL_FIFO_AFULL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srl16_fifo_ctrl #(
    parameter int WIDTH        = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             RD_EN,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] DOUT,
    output logic             EMPTY,
    output logic             FULL,
`ifdef SRL_FIFO_AFULL_EN
    output logic             ALMOST_FULL,
`endif
    output logic             SRL_CE,
    output logic [WIDTH-1:0] SRL_D,
    output logic [3:0]       SRL_A,
    input  logic [WIDTH-1:0] SRL_Q
);

    localparam logic [4:0] c_depth = 5'd16;

    // Threshold must address a real occupancy level of the 16-entry bank.
    generate
        if (AFULL_THRESH < 1 || AFULL_THRESH > 15) begin : g_thresh_check
            $error("srl16_fifo_ctrl: AFULL_THRESH must be within 1..15");
        end
    endgenerate

    logic [4:0]       r_cnt;
    logic             r_empty;
    logic             r_full;
    logic             r_srl_ce;
    logic [WIDTH-1:0] r_srl_d;
    logic [3:0]       r_srl_a;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [4:0]       w_cnt_nxt;
    logic [3:0]       w_srl_a_nxt;

    always_comb begin
        w_rd_acc = RD_EN & ~r_empty;
        w_wr_acc = WR_EN & (~r_full | w_rd_acc);
    end

    // A paired read+write leaves occupancy unchanged; the shift itself moves
    // the next-oldest word into the tap the address already selects.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (FLUSH) begin
            w_cnt_nxt = 5'd0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_cnt + 5'd1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_cnt - 5'd1;
        end
    end

    always_comb begin
        w_srl_a_nxt = 4'd0;
        if (w_cnt_nxt != 5'd0) begin
            w_srl_a_nxt = 4'(w_cnt_nxt - 5'd1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= 5'd0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_srl_ce <= 1'b0;
            r_srl_d  <= '0;
            r_srl_a  <= 4'd0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_empty  <= (w_cnt_nxt == 5'd0);
            r_full   <= (w_cnt_nxt == c_depth);
            // A flush drops any write presented in the same cycle.
            r_srl_ce <= w_wr_acc & ~FLUSH;
            r_srl_d  <= DIN;
            r_srl_a  <= w_srl_a_nxt;
        end
    end

`ifdef SRL_FIFO_AFULL_EN
    localparam logic [4:0] c_afull_thresh = 5'(AFULL_THRESH);

    logic r_almost_full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_cnt_nxt >= c_afull_thresh);
        end
    end

    assign ALMOST_FULL = r_almost_full;
`endif

    assign EMPTY  = r_empty;
    assign FULL   = r_full;
    assign SRL_CE = r_srl_ce;
    assign SRL_D  = r_srl_d;
    assign SRL_A  = r_srl_a;
    assign DOUT   = SRL_Q;

endmodule

`default_nettype wire
